// File: rtl/writeback_unit.sv
// Final RV32I pipeline stage: selects the writeback source, waits for load data,
// extracts/extends sub-word loads and drives the register-file write port.
module writeback_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc,
  input  logic [2:0]  in_funct3,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic        reg_write,
  output logic        wb_error
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT_MEM
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [4:0]         r_ld_rd, w_ld_rd_nxt;
  logic [2:0]         r_ld_funct3, w_ld_funct3_nxt;
  logic [1:0]         r_ld_addr, w_ld_addr_nxt;
  logic [4:0]         r_rd, w_rd_nxt;
  logic [31:0]        r_data, w_data_nxt;
  logic               r_reg_write, w_reg_write_nxt;
  logic               r_wb_error, w_wb_error_nxt;
  logic               w_load_ok;

  // Legal load type whose address is naturally aligned for its access size
  function automatic logic load_legal_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return ~a[0];
      3'b010:         return (a == 2'b00);
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  assign w_load_ok = load_legal_aligned(in_funct3, in_alu_result[1:0]);
  assign in_ready  = (r_state == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ld_rd     <= '0;
      r_ld_funct3 <= '0;
      r_ld_addr   <= '0;
      r_rd        <= '0;
      r_data      <= '0;
      r_reg_write <= 1'b0;
      r_wb_error  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ld_rd     <= w_ld_rd_nxt;
      r_ld_funct3 <= w_ld_funct3_nxt;
      r_ld_addr   <= w_ld_addr_nxt;
      r_rd        <= w_rd_nxt;
      r_data      <= w_data_nxt;
      r_reg_write <= w_reg_write_nxt;
      r_wb_error  <= w_wb_error_nxt;
    end
  end

  // Next-state and registered-output logic; rd/data hold unless something is written
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ld_rd_nxt     = r_ld_rd;
    w_ld_funct3_nxt = r_ld_funct3;
    w_ld_addr_nxt   = r_ld_addr;
    w_rd_nxt        = r_rd;
    w_data_nxt      = r_data;
    w_reg_write_nxt = 1'b0;
    w_wb_error_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          case (in_wb_sel)
            2'd0: begin
              w_rd_nxt        = in_rd;
              w_data_nxt      = in_alu_result;
              w_reg_write_nxt = (in_rd != 5'd0);
            end
            2'd2: begin
              w_rd_nxt        = in_rd;
              w_data_nxt      = in_pc + 32'd4;
              w_reg_write_nxt = (in_rd != 5'd0);
            end
            2'd1: begin
              if (w_load_ok) begin
                w_ld_rd_nxt     = in_rd;
                w_ld_funct3_nxt = in_funct3;
                w_ld_addr_nxt   = in_alu_result[1:0];
                w_cnt_nxt       = '0;
                w_state_nxt     = S_WAIT_MEM;
              end else begin
                w_wb_error_nxt  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      S_WAIT_MEM: begin
        // A response on the timeout edge still wins over the timeout
        if (mem_rvalid) begin
          w_rd_nxt        = r_ld_rd;
          w_data_nxt      = load_extract(r_ld_funct3, r_ld_addr, mem_rdata);
          w_reg_write_nxt = (r_ld_rd != 5'd0);
          w_cnt_nxt       = '0;
          w_state_nxt     = S_IDLE;
        end else if ((r_cnt + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT)) begin
          w_wb_error_nxt  = 1'b1;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_IDLE;
        end else begin
          w_cnt_nxt       = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rd        = r_rd;
  assign data      = r_data;
  assign reg_write = r_reg_write;
  assign wb_error  = r_wb_error;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by random
// instructions, all checked against a behavioural model of the writeback rules.
module tb_writeback_unit;

  localparam int unsigned T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rd;
  logic [31:0] data;
  logic        reg_write;
  logic        wb_error;

  int checks = 0;
  int errors = 0;

  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  writeback_unit #(.MEM_TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wb_sel(in_wb_sel),
    .in_alu_result(in_alu_result), .in_pc(in_pc), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd(rd), .data(data), .reg_write(reg_write), .wb_error(wb_error)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model: access size by load type; 0 means illegal
  function automatic int load_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit load_ok(input logic [2:0] f3, input logic [1:0] a);
    int sz = load_size(f3);
    return (sz != 0) && ((int'(a) % sz) == 0);
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] v = w >> (8 * int'(a));
    case (f3)
      3'b000: begin v = v & 32'h0000_00FF; if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = v & 32'h0000_FFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = v & 32'h0000_00FF;
      3'b101: v = v & 32'h0000_FFFF;
      default: ;
    endcase
    return v;
  endfunction

  // Check the cycle right after an instruction resolves
  task automatic expect_out(input string tag, input bit wr, input logic [4:0] r,
                            input logic [31:0] d, input bit err);
    if (wr) begin
      exp_rd   = r;
      exp_data = d;
    end
    chk({tag, "_reg_write"}, 32'(reg_write), 32'(wr && (r != 5'd0)));
    chk({tag, "_wb_error"},  32'(wb_error),  32'(err));
    chk({tag, "_rd"},        32'(rd),        32'(exp_rd));
    chk({tag, "_data"},      data,           exp_data);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // resp = WAIT_MEM edge (1-based) carrying mem_rvalid; resp > T means no response
  task automatic run_instr(input logic [1:0] sel, input logic [4:0] rdi, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [2:0] f3, input int resp,
                           input logic [31:0] rdata);
    bit done = 0;
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_wb_sel = sel; in_rd = rdi;
    in_alu_result = alu; in_pc = pc; in_funct3 = f3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    in_wb_sel = 2'($urandom); in_rd = 5'($urandom);
    in_alu_result = $urandom; in_pc = $urandom; in_funct3 = 3'($urandom);
    if (sel == 2'd0)      expect_out("alu", 1'b1, rdi, alu, 1'b0);
    else if (sel == 2'd2) expect_out("pc4", 1'b1, rdi, pc + 32'd4, 1'b0);
    else if (sel == 2'd3) expect_out("nowb", 1'b0, 5'd0, 32'd0, 1'b0);
    else if (!load_ok(f3, alu[1:0])) expect_out("ld_bad", 1'b0, 5'd0, 32'd0, 1'b1);
    else begin
      for (int j = 1; j <= int'(T); j++) begin
        if (!done) begin
          chk("wait_in_ready", 32'(in_ready), 32'd0);
          mem_rvalid = (j == resp);
          mem_rdata  = (j == resp) ? rdata : $urandom;
          @(posedge clock); #1;
          mem_rvalid = 1'b0;
          if (j == resp) begin
            expect_out("ld_wr", 1'b1, rdi, load_value(f3, alu[1:0], rdata), 1'b0);
            done = 1;
          end else if (j == int'(T)) begin
            expect_out("ld_timeout", 1'b0, 5'd0, 32'd0, 1'b1);
          end else begin
            chk("wait_reg_write", 32'(reg_write), 32'd0);
            chk("wait_wb_error",  32'(wb_error),  32'd0);
          end
        end
      end
    end
  endtask

  // Idle cycle with a stray mem_rvalid that must be ignored
  task automatic idle_cycle();
    in_valid   = 1'b0;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    expect_out("idle", 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  initial begin
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

    reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0;
    in_alu_result = '0; in_pc = '0; in_funct3 = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_rd = '0; exp_data = '0;
    #2;
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_wb_error", 32'(wb_error), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #10 reset = 1'b0;
    @(posedge clock); #1;

    // Back-to-back ALU writes
    run_instr(2'd0, 5'd5, 32'h1234_5678, 32'd0, 3'd0, 0, 32'd0);
    chk("alu1_const", data, 32'h1234_5678);
    run_instr(2'd0, 5'd6, 32'hFFFF_FFFF, 32'd0, 3'd0, 0, 32'd0);
    chk("alu2_const", data, 32'hFFFF_FFFF);

    // Sub-word load extension
    run_instr(2'd1, 5'd7, 32'h0000_1003, 32'd0, 3'b000, 1, 32'h80FF_0000);
    chk("lb_const", data, 32'hFFFF_FF80);
    run_instr(2'd1, 5'd7, 32'h0000_1003, 32'd0, 3'b100, 1, 32'h80FF_0000);
    chk("lbu_const", data, 32'h0000_0080);
    run_instr(2'd1, 5'd8, 32'h0000_2002, 32'd0, 3'b101, 2, 32'hBEEF_0000);
    chk("lhu_const", data, 32'h0000_BEEF);
    run_instr(2'd1, 5'd8, 32'h0000_2002, 32'd0, 3'b001, 3, 32'hBEEF_0000);
    chk("lh_const", data, 32'hFFFF_BEEF);

    // Misaligned LW and illegal funct3
    run_instr(2'd1, 5'd9, 32'h0000_3002, 32'd0, 3'b010, 1, 32'd0);
    run_instr(2'd1, 5'd9, 32'h0000_3000, 32'd0, 3'b011, 1, 32'd0);

    // Timeout, then response on the timeout edge
    run_instr(2'd1, 5'd10, 32'h0000_4000, 32'd0, 3'b010, int'(T) + 1, 32'd0);
    run_instr(2'd1, 5'd10, 32'h0000_4000, 32'd0, 3'b010, int'(T), 32'hA5A5_5A5A);
    chk("lw_edge_const", data, 32'hA5A5_5A5A);

    // PC+4 wrap and rd = 0
    run_instr(2'd2, 5'd11, 32'd0, 32'hFFFF_FFFC, 3'd0, 0, 32'd0);
    chk("pc4_wrap_const", data, 32'h0000_0000);
    run_instr(2'd0, 5'd0, 32'hCAFE_F00D, 32'd0, 3'd0, 0, 32'd0);
    chk("rd0_data_const", data, 32'hCAFE_F00D);
    idle_cycle();

    // Reset while waiting for a load response
    in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd12;
    in_alu_result = 32'h0000_5000; in_funct3 = 3'b010;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("rstwait_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    exp_rd = '0; exp_data = '0;
    chk("rstwait_rd", 32'(rd), 32'd0);
    chk("rstwait_data", data, 32'd0);
    chk("rstwait_in_ready", 32'(in_ready), 32'd1);
    chk("rstwait_reg_write", 32'(reg_write), 32'd0);
    #2 reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clock); #1;
    mem_rvalid = 1'b0;
    expect_out("rstwait_after", 1'b0, 5'd0, 32'd0, 1'b0);

    // Random instruction mix against the model
    for (int i = 0; i < 60; i++) begin
      sel  = 2'($urandom);
      addr = $urandom;
      f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) != 0 && load_size(f3) != 0)
        addr[1:0] = 2'(int'(addr[1:0]) / load_size(f3) * load_size(f3));
      run_instr(sel, 5'($urandom), addr, $urandom, f3,
                $urandom_range(1, int'(T) + 1), $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RV32I core and sole driver of the register file's write port (`rd`, `data`, `reg_write`). It accepts one retiring instruction at a time, selects the writeback source (ALU result, load data or PC+4), waits for the data-memory read response on loads, and performs byte/halfword extraction with sign or zero extension. Outputs are registered on the rising edge, so they are stable when the register file samples them on the falling edge.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent in WAIT_MEM before a load is abandoned; legal range 1–255.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: a retiring instruction is presented.
- `in_ready` out 1: unit can accept an instruction this cycle.
- `in_rd` in 5: destination register.
- `in_wb_sel` in 2: 0 = ALU, 1 = load, 2 = PC+4, 3 = no writeback.
- `in_alu_result` in 32: ALU result; for loads, the effective address.
- `in_pc` in 32: instruction PC.
- `in_funct3` in 3: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes are illegal.
- `mem_rvalid` in 1: read data valid, single-cycle pulse.
- `mem_rdata` in 32: aligned word containing the load address.
- `rd` out 5: register-file destination.
- `data` out 32: register-file write data.
- `reg_write` out 1: register-file write enable, one-cycle pulse.
- `wb_error` out 1: one-cycle pulse on a misaligned load, illegal funct3, or timeout.

## Operation
- FSM states: IDLE, WAIT_MEM. `in_ready` = (state == IDLE).
- Accept means `in_valid && in_ready` at a rising edge.
- **Accept, wb_sel 0:** `data` ← `in_alu_result`. The unit stays in IDLE.
- **Accept, wb_sel 2:** `data` ← `in_pc + 4`, modulo 2^32. The unit stays in IDLE.
- **Accept, wb_sel 3:** no write and no error. The unit stays in IDLE.
- **Accept, wb_sel 1, legal and aligned:**
  - Capture `rd`, funct3 and address bits [1:0].
  - Clear the timeout counter and go to WAIT_MEM.
  - Aligned means LH/LHU with addr[0] = 0, or LW with addr[1:0] = 0. LB and LBU are always aligned.
- **Accept, wb_sel 1, misaligned or illegal funct3:**
  - Pulse `wb_error` and do not write. The unit stays in IDLE.
  - Upstream must not issue a memory request for such loads.
- **Load extraction (WAIT_MEM with `mem_rvalid`):**
  - LB/LBU: byte at addr[1:0] (byte 0 = bits 7:0).
  - LH/LHU: halfword selected by addr[1] (0 = bits 15:0).
  - LW: the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - After extraction, write the result and return to IDLE.
- **WAIT_MEM without `mem_rvalid`:** the counter increments. When it reaches `MEM_TIMEOUT`, the unit pulses `wb_error`, does not write, and returns to IDLE.
- **`mem_rvalid` outside WAIT_MEM:** ignored.
- **`rd` = 0:** `reg_write` stays 0; `rd` and `data` still update. No error.
- **When nothing is written:** `rd` and `data` hold their previous values.

## Timing
- **Reset values:** state IDLE, `rd` = 0, `data` = 0, `reg_write` = 0, `wb_error` = 0, counter = 0.
  - Reset during WAIT_MEM abandons the load with no write.
  - A later `mem_rvalid` is ignored.
- **Non-load latency:** accept at edge N → `reg_write` high during cycle N..N+1. Back-to-back accepts give one write per cycle.
- **Load latency:** `mem_rvalid` sampled at edge M → `reg_write` high during cycle M..M+1. `in_ready` is high in that same cycle, so a new instruction can be accepted at edge M+1.
  - Minimum load latency: response in the cycle after accept → write two cycles after accept.
- **Timeout:** the load is abandoned at the `MEM_TIMEOUT`-th WAIT_MEM edge without `rvalid`.
  - If `mem_rvalid` arrives on that same edge, the response wins: write, no error.
  - `wb_error` pulses in the following cycle.
- **Pulse width:** `reg_write` and `wb_error` are never high for more than one consecutive cycle per instruction, and are never both high.

## Test plan
- **ALU writes:** accept wb_sel=0, rd=5, alu=0x1234_5678, then immediately rd=6, alu=0xFFFF_FFFF → `reg_write` pulses on two consecutive cycles with (5, 0x12345678) then (6, 0xFFFFFFFF); `in_ready` stays high.
- **Load extension:** LB addr=0x...03, rdata=0x80FF_0000 → 0xFFFF_FF80. LBU same → 0x0000_0080. LHU addr=0x...02, rdata=0xBEEF_0000 → 0x0000_BEEF. LH same → 0xFFFF_BEEF. Each writes one cycle after `rvalid`.
- **Misaligned and illegal:**
  - LW addr=0x...02 → `wb_error` pulse next cycle, no `reg_write`, `in_ready` stays high.
  - funct3=011 with wb_sel=1 → same response.
- **Timeout (`MEM_TIMEOUT`=4):**
  - Load with no `rvalid` → `in_ready` low for 4 cycles, then `wb_error` pulse, no write.
  - Repeat with `rvalid` on the 4th WAIT_MEM edge → write with no error.
- **PC+4 and rd=0:**
  - wb_sel=2, pc=0xFFFF_FFFC → data=0x0000_0000 with `reg_write`=1.
  - wb_sel=0, rd=0 → `reg_write`=0, `data` updated.
- **Reset during WAIT_MEM:** assert `reset` mid-load → outputs at reset values immediately; `mem_rvalid` after reset release → no write, `in_ready`=1.
